// File: rtl/ce_nco_pkg.sv
// rtl/ce_nco_pkg.sv - shared types, constants and helpers for the clock-enable NCO bank
//
// Holds the control FSM state enumeration, the channel-select width helper
// and the legal ranges of the bank parameters. No ports.

package ce_nco_pkg;

  // Legal parameter ranges for ce_nco_bank.
  localparam int NUM_CH_MIN      = 1;
  localparam int NUM_CH_MAX      = 8;
  localparam int ACC_W_MIN       = 8;
  localparam int ACC_W_MAX       = 32;
  localparam int LOCK_CYCLES_MIN = 2;

  typedef enum logic [1:0] {
    S_SETTLE = 2'd0,
    S_LOAD   = 2'd1,
    S_LOCKED = 2'd2
  } nco_state_t;

  // Channel-select width; a single channel still needs a 1-bit select port.
  function automatic int ch_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ce_nco_chan.sv
// rtl/ce_nco_chan.sv - single phase-accumulator clock-enable channel
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   load       one-cycle strobe: take load_inc/load_phase/load_en
//   load_inc   phase increment to install
//   load_phase accumulator preset to install
//   load_en    channel enable to install
//   ce         registered carry-out of the accumulator add
//   sq         accumulator MSB delayed by one register stage

module ce_nco_chan
  import ce_nco_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [ACC_W-1:0] load_inc,
  input  logic [ACC_W-1:0] load_phase,
  input  logic             load_en,
  output logic             ce,
  output logic             sq
);

  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] acc;
  logic             en;
  logic [ACC_W:0]   sum;

  // One extra bit captures the wrap of the modulo-2^ACC_W add.
  assign sum = {1'b0, acc} + {1'b0, inc};

  always_ff @(posedge clk) begin
    if (rst) begin
      inc <= '0;
      acc <= '0;
      en  <= 1'b0;
      ce  <= 1'b0;
      sq  <= 1'b0;
    end else if (load) begin
      // The load edge does not accumulate; the first add happens on the next edge.
      inc <= load_inc;
      acc <= load_phase;
      en  <= load_en;
      ce  <= 1'b0;
      sq  <= 1'b0;
    end else if (en) begin
      acc <= sum[ACC_W-1:0];
      ce  <= sum[ACC_W];
      sq  <= acc[ACC_W-1];
    end else begin
      ce  <= 1'b0;
      sq  <= 1'b0;
    end
  end

endmodule

// File: rtl/ce_nco_bank.sv
// rtl/ce_nco_bank.sv - bank of NCO clock-enable generators with config port and lock indicator
//
// Ports:
//   refclk     single clock, all logic on its rising edge
//   rst        synchronous active-high reset
//   cfg_valid  configuration word offered
//   cfg_ready  configuration word acceptable (low in S_LOAD and during reset)
//   cfg_ch     target channel; values >= NUM_CH are accepted and dropped
//   cfg_inc    phase increment per cycle
//   cfg_phase  accumulator preset
//   cfg_en     channel enable
//   ce         one-cycle clock-enable pulses, one bit per channel
//   sq         square-wave view of each channel
//   locked     configuration unchanged for LOCK_CYCLES cycles

module ce_nco_bank
  import ce_nco_pkg::*;
#(
  parameter int  NUM_CH      = 5,
  parameter int  ACC_W       = 32,
  parameter int  LOCK_CYCLES = 1024,
  localparam int CH_W        = ch_width(NUM_CH)
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [ACC_W-1:0]  cfg_phase,
  input  logic              cfg_en,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] sq,
  output logic              locked
);

  localparam int                CNT_W    = $clog2(LOCK_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CH_W:0]     NUM_CH_V = (CH_W + 1)'(NUM_CH);

  nco_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [CH_W-1:0]   stg_ch;
  logic [ACC_W-1:0]  stg_inc;
  logic [ACC_W-1:0]  stg_phase;
  logic              stg_en;
  logic              cfg_fire;
  logic              ch_ok;
  logic [NUM_CH-1:0] load_vec;

  assign cfg_ready = ~rst & (state != S_LOAD);
  assign cfg_fire  = cfg_valid & cfg_ready;
  // Widened compare so NUM_CH equal to 2^CH_W does not overflow.
  assign ch_ok     = ({1'b0, cfg_ch} < NUM_CH_V);

  always_ff @(posedge refclk) begin
    if (rst) begin
      state     <= S_SETTLE;
      cnt       <= CNT_INIT;
      locked    <= 1'b0;
      stg_ch    <= '0;
      stg_inc   <= '0;
      stg_phase <= '0;
      stg_en    <= 1'b0;
    end else if (cfg_fire && ch_ok) begin
      // Valid transfer from S_SETTLE or S_LOCKED; out-of-range channels
      // fall through below and leave the state and counter untouched.
      stg_ch    <= cfg_ch;
      stg_inc   <= cfg_inc;
      stg_phase <= cfg_phase;
      stg_en    <= cfg_en;
      state     <= S_LOAD;
      locked    <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          state  <= S_SETTLE;
          cnt    <= CNT_INIT;
          locked <= 1'b0;
        end
        S_SETTLE: begin
          if (cnt == '0) begin
            state  <= S_LOCKED;
            locked <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_LOCKED: begin
          locked <= 1'b1;
        end
        default: begin
          state  <= S_SETTLE;
          cnt    <= CNT_INIT;
          locked <= 1'b0;
        end
      endcase
    end
  end

  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_chan
      // The staged word is applied on the edge that leaves S_LOAD.
      assign load_vec[i] = (state == S_LOAD) && (stg_ch == CH_W'(i));

      ce_nco_chan #(
        .ACC_W (ACC_W)
      ) u_chan (
        .clk        (refclk),
        .rst        (rst),
        .load       (load_vec[i]),
        .load_inc   (stg_inc),
        .load_phase (stg_phase),
        .load_en    (stg_en),
        .ce         (ce[i]),
        .sq         (sq[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_ce_nco_bank.sv
// tb/tb_ce_nco_bank.sv - self-checking bench for ce_nco_bank

module tb_ce_nco_bank;

  localparam int NUM_CH = 5;
  localparam int ACC_W  = 8;
  localparam int LOCK   = 16;
  localparam int MODV   = 256;
  localparam int HALF   = 128;

  logic              refclk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [2:0]        cfg_ch = '0;
  logic [ACC_W-1:0]  cfg_inc = '0;
  logic [ACC_W-1:0]  cfg_phase = '0;
  logic              cfg_en = 1'b0;
  logic [NUM_CH-1:0] ce;
  logic [NUM_CH-1:0] sq;
  logic              locked;

  int total = 0;
  int bad = 0;

  ce_nco_bank #(
    .NUM_CH      (NUM_CH),
    .ACC_W       (ACC_W),
    .LOCK_CYCLES (LOCK)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_inc   (cfg_inc),
    .cfg_phase (cfg_phase),
    .cfg_en    (cfg_en),
    .ce        (ce),
    .sq        (sq),
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per-channel integer accumulators plus edge timestamps for lock.
  int m_inc[NUM_CH];
  int m_acc[NUM_CH];
  bit m_en[NUM_CH];
  bit m_ce[NUM_CH];
  bit m_sq[NUM_CH];
  bit in_load = 1'b0;
  int p_ch = 0, p_inc = 0, p_ph = 0;
  bit p_en = 1'b0;
  int edge_n = 0;
  int entry_edge = 0;

  always @(posedge refclk) begin
    int exp_ce, exp_sq, exp_lock, exp_rdy;
    edge_n++;
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_inc[c] = 0; m_acc[c] = 0; m_en[c] = 0; m_ce[c] = 0; m_sq[c] = 0;
      end
      in_load    = 1'b0;
      entry_edge = edge_n;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (in_load && p_ch == c) begin
          m_inc[c] = p_inc; m_acc[c] = p_ph; m_en[c] = p_en;
          m_ce[c] = 0; m_sq[c] = 0;
        end else if (m_en[c]) begin
          m_sq[c]  = (m_acc[c] >= HALF);
          m_ce[c]  = ((m_acc[c] + m_inc[c]) >= MODV);
          m_acc[c] = (m_acc[c] + m_inc[c]) % MODV;
        end else begin
          m_ce[c] = 0; m_sq[c] = 0;
        end
      end
      if (in_load) begin
        in_load    = 1'b0;
        entry_edge = edge_n;
      end else if (cfg_valid && int'(cfg_ch) < NUM_CH) begin
        in_load = 1'b1;
        p_ch = int'(cfg_ch); p_inc = int'(cfg_inc); p_ph = int'(cfg_phase); p_en = cfg_en;
      end
    end
    #1;
    exp_ce = 0;
    exp_sq = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      exp_ce += int'(m_ce[c]) << c;
      exp_sq += int'(m_sq[c]) << c;
    end
    exp_lock = (!in_load && (edge_n - entry_edge) >= LOCK) ? 1 : 0;
    exp_rdy  = (!rst && !in_load) ? 1 : 0;
    chk("mdl_ce", int'(ce), exp_ce);
    chk("mdl_sq", int'(sq), exp_sq);
    chk("mdl_locked", int'(locked), exp_lock);
    chk("mdl_ready", int'(cfg_ready), exp_rdy);
  end

  // Issues one transfer, returning at the negedge after the load edge.
  task automatic xfer(input int ch, input int inc, input int ph, input bit en);
    int w = 0;
    while (!cfg_ready && w < 8) begin
      @(negedge refclk);
      w++;
    end
    if (!cfg_ready) chk("xfer_ready_timeout", 0, 1);
    cfg_valid = 1'b1;
    cfg_ch    = 3'(ch);
    cfg_inc   = 8'(inc);
    cfg_phase = 8'(ph);
    cfg_en    = en;
    @(negedge refclk);
    cfg_valid = 1'b0;
    @(negedge refclk);
  endtask

  initial begin
    int cnt_ce, cnt_sq, w0, w1;
    bit [15:0] pat;

    // Reset held for 3 cycles.
    repeat (3) @(negedge refclk);
    chk("rst_ce", int'(ce), 0);
    chk("rst_sq", int'(sq), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_ready", int'(cfg_ready), 0);
    rst = 1'b0;
    for (int k = 1; k <= LOCK; k++) begin
      @(negedge refclk);
      chk("rel_locked", int'(locked), (k == LOCK) ? 1 : 0);
    end

    // ch0 inc=64: pulse every 4 cycles, square 2 high / 2 low.
    xfer(0, 64, 0, 1);
    cnt_ce = 0;
    cnt_sq = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge refclk);
      cnt_ce += int'(ce[0]);
      cnt_sq += int'(sq[0]);
    end
    chk("ch0_ce_count", cnt_ce, 4);
    chk("ch0_sq_high", cnt_sq, 8);

    // ch1 inc=96: 3 pulses in every 8-cycle window.
    xfer(1, 96, 0, 1);
    for (int k = 0; k < 16; k++) begin
      @(negedge refclk);
      pat[k] = ce[1];
    end
    w0 = $countones(pat[7:0]);
    w1 = $countones(pat[15:8]);
    chk("ch1_win0", w0, 3);
    chk("ch1_win1", w1, 3);
    chk("ch1_repeat", int'(pat[15:8]), int'(pat[7:0]));

    // ch2 inc=64 phase=192: wrap at T+2.
    cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_inc = 8'd64; cfg_phase = 8'd192; cfg_en = 1'b1;
    @(negedge refclk);
    cfg_valid = 1'b0;
    chk("ch2_ce_T", int'(ce[2]), 0);
    @(negedge refclk);
    chk("ch2_ce_T1", int'(ce[2]), 0);
    @(negedge refclk);
    chk("ch2_ce_T2", int'(ce[2]), 1);
    @(negedge refclk);
    chk("ch2_ce_T3", int'(ce[2]), 0);

    // Transfer to ch3 when the settle count is 5; relock 16 cycles after load.
    repeat (8) @(negedge refclk);
    cfg_valid = 1'b1; cfg_ch = 3'd3; cfg_inc = 8'd32; cfg_phase = 8'd0; cfg_en = 1'b1;
    @(negedge refclk);
    cfg_valid = 1'b0;
    chk("ch3_locked_T", int'(locked), 0);
    for (int k = 1; k <= LOCK + 1; k++) begin
      @(negedge refclk);
      chk("ch3_relock", int'(locked), (k == LOCK + 1) ? 1 : 0);
    end

    // Out-of-range channel while locked: discarded.
    cfg_valid = 1'b1; cfg_ch = 3'd7; cfg_inc = 8'd200; cfg_phase = 8'd77; cfg_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge refclk);
      cfg_valid = 1'b0;
      chk("ch7_locked", int'(locked), 1);
      chk("ch7_ready", int'(cfg_ready), 1);
    end

    // ch4 inc=128 then a one-cycle reset pulse.
    xfer(4, 128, 0, 1);
    @(negedge refclk);
    chk("ch4_ce_T2", int'(ce[4]), 0);
    @(negedge refclk);
    chk("ch4_ce_T3", int'(ce[4]), 1);
    rst = 1'b1;
    @(negedge refclk);
    chk("ch4_rst_ce", int'(ce[4]), 0);
    chk("ch4_rst_locked", int'(locked), 0);
    rst = 1'b0;
    for (int k = 1; k <= LOCK; k++) begin
      @(negedge refclk);
      chk("post_rst_ce", int'(ce), 0);
      chk("post_rst_locked", int'(locked), (k == LOCK) ? 1 : 0);
    end

    // inc=0 with en=1: no pulses, constant square level.
    xfer(1, 0, 200, 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge refclk);
      chk("inc0_ce", int'(ce[1]), 0);
      chk("inc0_sq", int'(sq[1]), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ce_nco_bank.md
CE_NCO_BANK -- requirements
Module: ce_nco_bank

Interface
REQ-001 Parameter NUM_CH, default 5, meaning: number of clock-enable channels, legal range 1..8.
REQ-002 Parameter ACC_W, default 32, meaning: phase-accumulator width, legal range 8..32.
REQ-003 Parameter LOCK_CYCLES, default 1024, meaning: settle time in refclk cycles before locked asserts, minimum 2.
REQ-004 refclk  in  1  the single clock; all logic on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 cfg_valid  in  1  configuration word offered.
REQ-007 cfg_ready  out  1  configuration word acceptable; transfer occurs when cfg_valid & cfg_ready at a rising edge.
REQ-008 cfg_ch  in  CH_W  target channel, CH_W = max(1, clog2(NUM_CH)).
REQ-009 cfg_inc  in  ACC_W  phase increment per cycle.
REQ-010 cfg_phase  in  ACC_W  accumulator preset value.
REQ-011 cfg_en  in  1  channel enable.
REQ-012 ce  out  NUM_CH  one-cycle clock-enable pulses, one bit per channel.
REQ-013 sq  out  NUM_CH  square-wave view of each channel (accumulator MSB, registered).
REQ-014 locked  out  1  all channel configurations stable for LOCK_CYCLES cycles.

Function
REQ-015 Each channel SHALL hold inc, acc, en registers; when en=1, acc <= (acc + inc) mod 2^ACC_W every cycle; ce[i] SHALL be the registered carry-out of that add, so average ce rate = f_refclk * inc / 2^ACC_W.
REQ-016 sq[i] SHALL equal acc[i][ACC_W-1] delayed by one register stage.
REQ-017 When en=0, the channel SHALL hold acc and drive ce[i]=0, sq[i]=0.
REQ-018 inc=0 with en=1 SHALL produce no ce pulses and a constant sq.
REQ-019 Control FSM states: S_SETTLE, S_LOAD, S_LOCKED.
REQ-020 Transfer at edge T (any state except S_LOAD, cfg_ch < NUM_CH) SHALL capture cfg_* into staging and move to S_LOAD; cfg_ready=0 throughout S_LOAD.
REQ-021 At edge T+1 (leaving S_LOAD) the target channel SHALL load inc=cfg_inc, acc=cfg_phase, en=cfg_en; FSM enters S_SETTLE with counter = LOCK_CYCLES-1; first accumulate at edge T+2.
REQ-022 S_SETTLE SHALL decrement the counter each cycle and enter S_LOCKED when it is 0; locked = (state == S_LOCKED), registered, rising exactly LOCK_CYCLES cycles after entry to S_SETTLE.
REQ-023 A transfer during S_SETTLE or S_LOCKED SHALL deassert locked on the next cycle and restart the settle count from LOCK_CYCLES-1 after S_LOAD.
REQ-024 A transfer with cfg_ch >= NUM_CH SHALL be accepted and discarded: no channel change, FSM state and counter unaffected.
REQ-025 Untargeted channels SHALL continue accumulating unaffected by any transfer.
REQ-026 cfg_ready SHALL be 1 in S_SETTLE and S_LOCKED, 0 in S_LOAD and while rst=1.

Reset
REQ-027 While rst=1 at an edge: all inc, acc = 0, en = 0, ce = 0, sq = 0, locked = 0, staging cleared, FSM <= S_SETTLE, counter <= LOCK_CYCLES-1.
REQ-028 Reset asserted mid-operation (including during S_LOAD) SHALL discard the pending configuration; locked SHALL rise LOCK_CYCLES cycles after the first edge with rst=0.

Structure
REQ-029 Package ce_nco_pkg SHALL hold the FSM state enumeration, the CH_W computation function, and parameter legal-range constants.
REQ-030 One sub-module ce_nco_chan (single accumulator, ce/sq registers, load port) SHALL be instantiated NUM_CH times by a generate loop.

Verification (bench parameters: ACC_W=8, NUM_CH=5, LOCK_CYCLES=16)
REQ-031 rst high 3 cycles -> ce=0, sq=0, locked=0, cfg_ready=0; after release locked=1 exactly 16 cycles later.
REQ-032 ch0 inc=64, phase=0, en=1 -> ce[0] one pulse every 4 cycles; sq[0] 2 cycles high / 2 cycles low.
REQ-033 ch1 inc=96, phase=0 -> exactly 3 ce[1] pulses in every 8-cycle window, pattern repeating every 8 cycles.
REQ-034 ch2 inc=64, phase=192, transfer at edge T -> acc wraps at edge T+2, ce[2] high in the cycle after T+2.
REQ-035 Transfer to ch3 at settle count 5 -> locked held 0, relocks 16 cycles after S_LOAD; cfg_ch=7 transfer while locked -> locked stays 1, no channel changes.
REQ-036 ch4 running inc=128, rst pulsed 1 cycle -> ce[4]=0 next cycle, channel disabled, locked=0 for 16 cycles.
